// File: rtl/gauss_pkg.sv
// -----------------------------------------------------------------------------
// gauss_pkg
// Shared definitions for the streaming 3x3 Gaussian convolution block:
//   - word addresses of the Avalon-MM register map
//   - CTRL / STATUS bit positions
//   - reset kernel (1 2 1 / 2 4 2 / 1 2 1) and reset normalising shift
//   - FSM state type
//   - sum_width(): accumulator width for a given pixel/coefficient width
// -----------------------------------------------------------------------------
package gauss_pkg;

    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_WIDTH  = 5'd2;
    localparam logic [4:0] ADDR_SHIFT  = 5'd3;
    localparam logic [4:0] ADDR_PIXEL  = 5'd4;
    localparam logic [4:0] ADDR_RESULT = 5'd5;
    localparam logic [4:0] ADDR_COEF0  = 5'd8;
    localparam logic [4:0] ADDR_COEF8  = 5'd16;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UDF_BIT   = 3;
    localparam int STAT_LEVEL_LSB = 16;

    localparam int NUM_TAPS      = 9;
    localparam int DEFAULT_SHIFT = 4;

    // Row-major reset kernel, k0 is the top-left tap
    localparam int DEFAULT_COEF [NUM_TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } gauss_state_t;

    // Nine products of PIX_W+COEF_W bits need four extra bits of headroom
    function automatic int sum_width(input int pix_w, input int coef_w);
        return pix_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// -----------------------------------------------------------------------------
// gauss_line_buf
// Two-line pixel history, MAX_WIDTH words of 2*PIX_W bits, indexed by column.
// Each word holds {pixel two rows up, pixel one row up} for that column. On a
// push the word is read asynchronously and rewritten with the incoming pixel
// shifted in, so the buffer always holds the two rows above the current one.
//
// Ports:
//   clk     clock
//   push    accepted pixel this cycle
//   col     current column (read and write address)
//   pix_in  incoming pixel
//   top     pixel from two rows above at col
//   mid     pixel from one row above at col
// -----------------------------------------------------------------------------
module gauss_line_buf #(
    parameter int PIX_W     = 8,
    parameter int MAX_WIDTH = 640,
    localparam int AW       = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1
) (
    input  logic             clk,
    input  logic             push,
    input  logic [AW-1:0]    col,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] top,
    output logic [PIX_W-1:0] mid
);

    logic [2*PIX_W-1:0] mem [MAX_WIDTH];
    logic [2*PIX_W-1:0] rd_word;

    assign rd_word = mem[col];
    assign top     = rd_word[2*PIX_W-1:PIX_W];
    assign mid     = rd_word[PIX_W-1:0];

    // The old "one row up" pixel ages into the "two rows up" slot
    always_ff @(posedge clk) begin
        if (push) begin
            mem[col] <= {rd_word[PIX_W-1:0], pix_in};
        end
    end

endmodule

// File: rtl/gauss_conv_stream.sv
// -----------------------------------------------------------------------------
// gauss_conv_stream
// Streaming 3x3 convolution on an Avalon-MM slave. The CPU writes pixels in
// raster order to PIXEL_IN; every complete 3x3 window produces one filtered
// pixel that lands in an output FIFO, popped by reading RESULT.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   addr   word address
//   wdata  write data
//   rdata  registered read data
//   cs     chip select
//   read   read strobe
//   write  write strobe
//   irq    level interrupt: FIFO at least half full, or overflow flag set
//
// Build option:
//   GAUSS_SIGNED_COEF_EN  coefficients are two's complement, the sum is
//                         signed and negative results clamp to 0.
// -----------------------------------------------------------------------------
module gauss_conv_stream
    import gauss_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 4,
    parameter int MAX_WIDTH  = 640,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    output logic        irq
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int SW = sum_width(PIX_W, COEF_W);
`ifdef GAUSS_SIGNED_COEF_EN
    localparam int PW    = PIX_W + COEF_W + 1;
    localparam int ACC_W = SW + 1;
`else
    localparam int PW    = PIX_W + COEF_W;
    localparam int ACC_W = SW;
`endif
    localparam logic [FW:0] FULL_LVL = (FW+1)'(FIFO_DEPTH);
    localparam logic [FW:0] HALF_LVL = (FW+1)'(FIFO_DEPTH / 2);

    // Bus decode
    logic bus_wr, bus_rd;
    logic push, rd_result, pop;
    logic unused_wdata;

    assign bus_wr       = cs & write;
    assign bus_rd       = cs & read;
    assign unused_wdata = ^wdata[31:16];

    // Configuration registers
    logic               enable;
    logic               clr_q;
    logic [15:0]        width;
    logic [15:0]        width_in;
    logic [3:0]         shift;
    logic [COEF_W-1:0]  coef [NUM_TAPS];

    // Stream state
    gauss_state_t       state, state_nxt;
    logic [15:0]        col;
    logic [1:0]         row;
    logic               win_valid;
    logic [PIX_W-1:0]   lb_top, lb_mid;
    logic [PIX_W-1:0]   win [NUM_TAPS];
    logic               v1, v2;

    // Arithmetic
`ifdef GAUSS_SIGNED_COEF_EN
    logic signed [PW-1:0]    prod_c [NUM_TAPS];
    logic signed [PW-1:0]    prod_q [NUM_TAPS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;
`else
    logic [PW-1:0]           prod_c [NUM_TAPS];
    logic [PW-1:0]           prod_q [NUM_TAPS];
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        shifted;
`endif
    logic [PIX_W-1:0]        res;

    // Output FIFO
    logic [PIX_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]      wr_ptr, rd_ptr;
    logic [FW:0]        count;
    logic               empty, full, fifo_wr;
    logic               ovf, udf;

    logic [31:0]        rd_mux;
    logic [3:0]         coef_idx;

    // Clear is registered into a one-cycle pulse so that a pixel write landing
    // in the pulse cycle can be discarded rather than racing the flush.
    assign push      = bus_wr && (addr == ADDR_PIXEL) && enable && !clr_q;
    assign rd_result = bus_rd && (addr == ADDR_RESULT);
    assign pop       = rd_result && !empty;

    // Out-of-range widths are clamped so the counters always see 3..MAX_WIDTH
    always_comb begin
        width_in = wdata[15:0];
        if (wdata[15:0] < 16'd3) begin
            width_in = 16'd3;
        end else if (wdata[15:0] > 16'(MAX_WIDTH)) begin
            width_in = 16'(MAX_WIDTH);
        end
    end

    // Programmable registers. Width is frozen while enabled so the column
    // counter never sees its wrap point move underneath it.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable <= 1'b0;
            clr_q  <= 1'b0;
            width  <= 16'(MAX_WIDTH);
            shift  <= 4'(DEFAULT_SHIFT);
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= COEF_W'(DEFAULT_COEF[k]);
            end
        end else begin
            clr_q <= bus_wr && (addr == ADDR_CTRL) && wdata[CTRL_CLR_BIT];
            if (bus_wr && (addr == ADDR_CTRL)) begin
                enable <= wdata[CTRL_EN_BIT];
            end
            if (bus_wr && (addr == ADDR_WIDTH) && !enable) begin
                width <= width_in;
            end
            if (bus_wr && (addr == ADDR_SHIFT)) begin
                shift <= wdata[3:0];
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (bus_wr && (addr == ADDR_COEF0 + 5'(k))) begin
                    coef[k] <= wdata[COEF_W-1:0];
                end
            end
        end
    end

    // Frame-progress state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE waits for enable, FILL waits for the first two rows to be buffered,
    // RUN produces results. Counters and buffers are untouched by leaving RUN,
    // so re-enabling resumes where the frame stopped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable && !clr_q) state_nxt = ST_FILL;
            ST_FILL: begin
                if (!enable || clr_q) begin
                    state_nxt = ST_IDLE;
                end else if (row == 2'd2) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (!enable || clr_q) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    gauss_line_buf #(
        .PIX_W     (PIX_W),
        .MAX_WIDTH (MAX_WIDTH)
    ) u_line_buf (
        .clk    (clk),
        .push   (push),
        .col    (col[AW-1:0]),
        .pix_in (wdata[PIX_W-1:0]),
        .top    (lb_top),
        .mid    (lb_mid)
    );

    // A window is complete once two full rows are behind us and the current
    // row has supplied at least three columns; no border padding is produced.
    assign win_valid = (row == 2'd2) && (col >= 16'd2);

    // Column/row counters and the 3x3 window. win[3r+c] is row r (0 = oldest)
    // and column c (2 = newest). The wrap test uses >= so a stale column
    // beyond a shrunken width still wraps instead of running away.
    always_ff @(posedge clk) begin
        if (rst || clr_q) begin
            col <= '0;
            row <= '0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                win[k] <= '0;
            end
        end else begin
            v1 <= push && win_valid;
            v2 <= v1;
            if (push) begin
                if (col >= width - 16'd1) begin
                    col <= '0;
                    if (row != 2'd2) begin
                        row <= row + 2'd1;
                    end
                end else begin
                    col <= col + 16'd1;
                end
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= lb_top;
                win[5] <= lb_mid;
                win[8] <= wdata[PIX_W-1:0];
            end
        end
    end

    // Per-tap products, operands widened first so nothing is lost
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef GAUSS_SIGNED_COEF_EN
            prod_c[k] = signed'({{(COEF_W+1){1'b0}}, win[k]})
                      * signed'({{(PIX_W+1){coef[k][COEF_W-1]}}, coef[k]});
`else
            prod_c[k] = {{COEF_W{1'b0}}, win[k]} * {{PIX_W{1'b0}}, coef[k]};
`endif
        end
    end

    // Stage-1 product register; validity travels in v2
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_q[k] <= prod_c[k];
        end
    end

    // Stage 2: sum, normalising shift and clamp into the pixel range
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
`ifdef GAUSS_SIGNED_COEF_EN
        shifted = acc >>> shift;
        if (shifted[ACC_W-1]) begin
            res = '0;
        end else if (|shifted[ACC_W-2:PIX_W]) begin
            res = '1;
        end else begin
            res = shifted[PIX_W-1:0];
        end
`else
        shifted = acc >> shift;
        if (|shifted[ACC_W-1:PIX_W]) begin
            res = '1;
        end else begin
            res = shifted[PIX_W-1:0];
        end
`endif
    end

    // A full FIFO still accepts a result if a pop frees a slot this cycle
    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign fifo_wr = v2 && (!full || pop);

    // FIFO pointers, level and sticky error flags. A flag being set wins over
    // a simultaneous write-1-to-clear so the event is not lost.
    always_ff @(posedge clk) begin
        if (rst || clr_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (v2 && full && !pop) begin
                ovf <= 1'b1;
            end else if (bus_wr && (addr == ADDR_STATUS) && wdata[STAT_OVF_BIT]) begin
                ovf <= 1'b0;
            end
            if (rd_result && empty) begin
                udf <= 1'b1;
            end else if (bus_wr && (addr == ADDR_STATUS) && wdata[STAT_UDF_BIT]) begin
                udf <= 1'b0;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= res;
        end
    end

    assign irq      = (count >= HALF_LVL) || ovf;
    assign coef_idx = 4'(addr - ADDR_COEF0);

    // Read-data mux; unmapped and write-only addresses read as zero
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:   rd_mux[CTRL_EN_BIT] = enable;
            ADDR_STATUS: begin
                rd_mux[STAT_EMPTY_BIT]          = empty;
                rd_mux[STAT_FULL_BIT]           = full;
                rd_mux[STAT_OVF_BIT]            = ovf;
                rd_mux[STAT_UDF_BIT]            = udf;
                rd_mux[STAT_LEVEL_LSB +: 8]     = 8'(count);
            end
            ADDR_WIDTH:  rd_mux[15:0] = width;
            ADDR_SHIFT:  rd_mux[3:0]  = shift;
            ADDR_RESULT: if (!empty) rd_mux[PIX_W-1:0] = fifo_mem[rd_ptr];
            default: begin
                if ((addr >= ADDR_COEF0) && (addr <= ADDR_COEF8)) begin
                    rd_mux[COEF_W-1:0] = coef[coef_idx];
                end
            end
        endcase
    end

    // rdata only moves on a read and otherwise holds its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (bus_rd) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gauss_conv_stream.sv
// -----------------------------------------------------------------------------
// tb_gauss_conv_stream
// Directed bench for gauss_conv_stream. Read expectations are queued when a
// read is issued; a monitor pops and compares them when rdata is presented
// one cycle later.
// -----------------------------------------------------------------------------
module tb_gauss_conv_stream;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        cs;
    logic        read;
    logic        write;
    logic        irq;

    localparam logic [4:0] A_CTRL   = 5'd0;
    localparam logic [4:0] A_STATUS = 5'd1;
    localparam logic [4:0] A_WIDTH  = 5'd2;
    localparam logic [4:0] A_SHIFT  = 5'd3;
    localparam logic [4:0] A_PIXEL  = 5'd4;
    localparam logic [4:0] A_RESULT = 5'd5;
    localparam logic [4:0] A_COEF0  = 5'd8;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic rd_pending  = 1'b0;

    gauss_conv_stream #(
        .PIX_W      (8),
        .COEF_W     (4),
        .MAX_WIDTH  (640),
        .FIFO_DEPTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .cs    (cs),
        .read  (read),
        .write (write),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus write cycle
    task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wdata = d;
    endtask

    // One bus read cycle; the expected rdata goes to the scoreboard
    task automatic busRead(input logic [4:0] a, input string name, input logic [31:0] exp);
        @(negedge clk);
        cs = 1'b1; write = 1'b0; read = 1'b1; addr = a; wdata = '0;
        sb.push_back('{name, exp});
    endtask

    task automatic busIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0; write = 1'b0; read = 1'b0;
        end
    endtask

    task automatic pushN(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) applyStimulus(A_PIXEL, 32'(v));
    endtask

    // Nine 4-bit coefficients packed k0 in the low nibble
    task automatic writeCoefs(input logic [35:0] c);
        for (int k = 0; k < 9; k++) applyStimulus(A_COEF0 + 5'(k), 32'(c[4*k +: 4]));
    endtask

    // Pixels 10, 20, ... 90 as a 3x3 frame
    task automatic pushRamp();
        for (int i = 1; i <= 9; i++) applyStimulus(A_PIXEL, 32'(i * 10));
    endtask

    // rdata is valid on the cycle after the read strobe was sampled
    always @(posedge clk) rd_pending <= cs & read;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rd_pending) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_read", rdata, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput(e.name, rdata, e.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        rst = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        busRead(A_STATUS, "rst_status", 32'h0000_0001);
        busRead(A_WIDTH, "rst_width", 32'd640);
        busRead(A_SHIFT, "rst_shift", 32'd4);
        busRead(A_COEF0 + 5'd4, "rst_coef4", 32'd4);
        busRead(A_COEF0 + 5'd1, "rst_coef1", 32'd2);
        busRead(A_CTRL, "rst_ctrl", 32'd0);
        busRead(5'd7, "unmapped", 32'd0);

        $display("[TB] width clamp");
        applyStimulus(A_WIDTH, 32'd1);
        busRead(A_WIDTH, "clamp_lo", 32'd3);
        applyStimulus(A_WIDTH, 32'd1000);
        busRead(A_WIDTH, "clamp_hi", 32'd640);

        $display("[TB] width 4, flat 100");
        applyStimulus(A_WIDTH, 32'd4);
        applyStimulus(A_CTRL, 32'd1);
        applyStimulus(A_WIDTH, 32'd7);
        busRead(A_WIDTH, "width_locked", 32'd4);
        pushN(16, 8'd100);
        busIdle(4);
        checkOutput("t1_irq", 32'(irq), 32'd0);
        busRead(A_STATUS, "t1_level4", 32'h0004_0000);
        for (int i = 0; i < 4; i++) busRead(A_RESULT, "t1_result", 32'd100);
        busRead(A_STATUS, "t1_empty", 32'h0000_0001);

        $display("[TB] width 3 ramp");
        applyStimulus(A_CTRL, 32'd2);
        applyStimulus(A_WIDTH, 32'd3);
        applyStimulus(A_CTRL, 32'd1);
        pushRamp();
        busIdle(4);
        busRead(A_RESULT, "t2_result", 32'd50);
        busRead(A_STATUS, "t2_empty", 32'h0000_0001);

        $display("[TB] saturation");
        applyStimulus(A_CTRL, 32'd2);
        writeCoefs(36'hFFFF_FFFFF);
        applyStimulus(A_SHIFT, 32'd0);
        applyStimulus(A_CTRL, 32'd1);
        pushN(9, 8'd255);
        busIdle(4);
`ifdef GAUSS_SIGNED_COEF_EN
        busRead(A_RESULT, "t3_result", 32'd0);
`else
        busRead(A_RESULT, "t3_result", 32'd255);
`endif
        applyStimulus(A_CTRL, 32'd2);
        writeCoefs(36'h1_2124_2121);
        applyStimulus(A_SHIFT, 32'd4);

        $display("[TB] overflow");
        applyStimulus(A_WIDTH, 32'd18);
        applyStimulus(A_CTRL, 32'd1);
        pushN(72, 8'd1);
        busIdle(4);
        checkOutput("t4_irq", 32'(irq), 32'd1);
        busRead(A_STATUS, "t4_full_ovf", 32'h0010_0006);
        applyStimulus(A_STATUS, 32'd4);
        busRead(A_STATUS, "t4_ovf_cleared", 32'h0010_0002);
        busRead(A_RESULT, "t4_first", 32'd1);
        busRead(A_STATUS, "t4_level15", 32'h000F_0000);
        busIdle(1);
        checkOutput("t4_irq_level", 32'(irq), 32'd1);

        $display("[TB] underflow and clear");
        applyStimulus(A_CTRL, 32'd2);
        busIdle(2);
        checkOutput("t5_irq", 32'(irq), 32'd0);
        busRead(A_STATUS, "t5_cleared", 32'h0000_0001);
        busRead(A_RESULT, "t5_empty_data", 32'd0);
        busRead(A_STATUS, "t5_underflow", 32'h0000_0009);
        applyStimulus(A_STATUS, 32'd8);
        busRead(A_STATUS, "t5_udf_cleared", 32'h0000_0001);
        applyStimulus(A_WIDTH, 32'd3);
        applyStimulus(A_CTRL, 32'd1);
        pushN(5, 8'd7);
        applyStimulus(A_CTRL, 32'd3);
        applyStimulus(A_PIXEL, 32'd0);
        pushRamp();
        busIdle(4);
        busRead(A_STATUS, "t5_level1", 32'h0001_0000);
        busRead(A_RESULT, "t5_result", 32'd50);
        busRead(A_STATUS, "t5_empty", 32'h0000_0001);

`ifdef GAUSS_SIGNED_COEF_EN
        $display("[TB] signed kernel");
        applyStimulus(A_CTRL, 32'd2);
        applyStimulus(A_SHIFT, 32'd0);
        writeCoefs(36'h0_F0F4_F0F0);
        applyStimulus(A_CTRL, 32'd1);
        pushN(9, 8'd50);
        busIdle(4);
        busRead(A_RESULT, "sgn_flat", 32'd0);
        applyStimulus(A_CTRL, 32'd3);
        busIdle(1);
        pushN(4, 8'd10);
        applyStimulus(A_PIXEL, 32'd200);
        pushN(4, 8'd10);
        busIdle(4);
        busRead(A_RESULT, "sgn_peak", 32'd255);
`endif

        busIdle(1);
        budget = 0;
        while ((sb.size() != 0) && (budget < 20)) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
